// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register bridge.
//   ADDR_WIDTH  : width of the I2C device address
//   DATA_WIDTH  : width of a register / bus data byte
//   i2c_state_t : protocol engine states
package i2c_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    ADDR_ACK = 4'd2,
    REG_PTR  = 4'd3,
    PTR_ACK  = 4'd4,
    WR_DATA  = 4'd5,
    WR_ACK   = 4'd6,
    RD_DATA  = 4'd7,
    RD_ACK   = 4'd8,
    IGNORE   = 4'd9
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA pins and derives bus events.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   scl_i/sda_i: raw asynchronous pin levels
//   scl_rise   : one-cycle pulse, SCL went 0->1
//   scl_fall   : one-cycle pulse, SCL went 1->0
//   start_det  : one-cycle pulse, SDA fell while SCL high
//   stop_det   : one-cycle pulse, SDA rose while SCL high
//   sda_smp    : SDA level aligned with the event pulses
// Pin-to-pulse latency is 3 clk: two synchronizer flops, then a registered
// compare of the synchronized level against its previous value.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_smp
);

  logic scl_s1, scl_s2, scl_q;
  logic sda_s1, sda_s2, sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_q     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_smp   <= 1'b1;
    end else begin
      scl_s1    <= scl_i;
      scl_s2    <= scl_s1;
      scl_q     <= scl_s2;
      sda_s1    <= sda_i;
      sda_s2    <= sda_s1;
      sda_q     <= sda_s2;
      scl_rise  <= scl_s2 & ~scl_q;
      scl_fall  <= ~scl_s2 & scl_q;
      // SCL must be high both before and after the SDA transition.
      start_det <= scl_s2 & scl_q & sda_q & ~sda_s2;
      stop_det  <= scl_s2 & scl_q & ~sda_q & sda_s2;
      sda_smp   <= sda_s2;
    end
  end

endmodule

// File: rtl/i2c_slave_reg_bridge.sv
// I2C slave protocol engine bridging bus transactions to a register map.
// Ports:
//   clk, rst_n   : system clock (>= 16x SCL), asynchronous active-low reset
//   scl_i, sda_i : raw pin levels
//   sda_oe       : 1 = pull SDA low (open drain)
//   reg_addr     : auto-incrementing register pointer
//   reg_wdata    : write data, valid while reg_wen is high
//   reg_wen      : one-cycle write strobe
//   reg_ren      : one-cycle read strobe; reg_rdata is captured that cycle
//   reg_rdata    : combinational read data from the map
//   busy         : high from an address-matched START until STOP
// Register-map handshake: there is no back-pressure. reg_wen and reg_ren are
// single-cycle strobes qualified by reg_addr in the same cycle; the map must
// accept a write and present reg_rdata combinationally within that cycle.
module i2c_slave_reg_bridge
  import i2c_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h42,
  parameter bit                    AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wen,
  output logic                  reg_ren,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_smp;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_smp   (sda_smp)
  );

  i2c_state_t            state, state_n;
  logic [2:0]            bit_cnt, cnt_n;
  logic [6:0]            rx_sr, rx_n;     // first 7 bits of the incoming byte
  logic [6:0]            tx_sr, tx_n;     // bits still to send after the MSB
  logic                  rw, rw_n;
  logic                  rd_more, more_n; // master ACKed, fetch next byte
  logic [DATA_WIDTH-1:0] addr_n, wdata_n;
  logic                  wen_n, oe_n, busy_n;
  logic [DATA_WIDTH-1:0] rx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 7'd0;
      rw        <= 1'b0;
      rd_more   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wen   <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      rx_sr     <= rx_n;
      tx_sr     <= tx_n;
      rw        <= rw_n;
      rd_more   <= more_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_wen   <= wen_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
    end
  end

  // In the three ACK-sending states sda_oe doubles as the phase flag: the
  // first scl_fall asserts it, the second releases it and moves on.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    rx_n    = rx_sr;
    tx_n    = tx_sr;
    rw_n    = rw;
    more_n  = rd_more;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;
    wen_n   = 1'b0;
    oe_n    = sda_oe;
    busy_n  = busy;
    reg_ren = 1'b0;
    rx_byte = {rx_sr, sda_smp};

    if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = 3'd0;
    end else if (start_det) begin
      state_n = DEV_ADDR;
      oe_n    = 1'b0;
      cnt_n   = 3'd0;
    end else begin
      case (state)
        DEV_ADDR, REG_PTR, WR_DATA: begin
          if (scl_rise) begin
            rx_n  = rx_byte[6:0];
            cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              cnt_n = 3'd0;
              if (state == DEV_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  busy_n  = 1'b1;
                  rw_n    = rx_byte[0];
                  state_n = ADDR_ACK;
                end else begin
                  state_n = IGNORE;
                end
              end else if (state == REG_PTR) begin
                addr_n  = rx_byte;
                state_n = PTR_ACK;
              end else begin
                wdata_n = rx_byte;
                wen_n   = 1'b1;
                state_n = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = 3'd0;
            if (!sda_oe) begin
              oe_n = 1'b1;
            end else if (rw) begin
              reg_ren = 1'b1;
              tx_n    = reg_rdata[6:0];
              oe_n    = ~reg_rdata[7];
              state_n = RD_DATA;
            end else begin
              oe_n    = 1'b0;
              state_n = REG_PTR;
            end
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            cnt_n = 3'd0;
            if (!sda_oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n    = 1'b0;
              state_n = WR_DATA;
              if (state == WR_ACK && AUTO_INC) addr_n = reg_addr + 8'd1;
            end
          end
        end
        RD_DATA: begin
          // MSB went out with the load; falls 1..7 send the rest, fall 8
          // releases SDA for the master's ACK bit.
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              oe_n    = 1'b0;
              cnt_n   = 3'd0;
              more_n  = 1'b0;
              state_n = RD_ACK;
            end else begin
              tx_n  = {tx_sr[5:0], 1'b0};
              oe_n  = ~tx_sr[6];
              cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_smp) begin
              more_n = 1'b1;
              if (AUTO_INC) addr_n = reg_addr + 8'd1;
            end else begin
              oe_n    = 1'b0;
              state_n = IGNORE;
            end
          end else if (scl_fall && rd_more) begin
            reg_ren = 1'b1;
            tx_n    = reg_rdata[6:0];
            oe_n    = ~reg_rdata[7];
            cnt_n   = 3'd0;
            state_n = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_reg_bridge.md
Name: i2c_slave_reg_bridge

Overview:
I2C slave protocol engine that turns bus transactions into single-cycle register accesses for the board's register map (SW/LED/FND registers at 0x00–0x03). It decodes START/STOP, matches the 7-bit device address, and holds an auto-incrementing register pointer. On writes it issues one write strobe per data byte; on reads it fetches a byte with a read strobe and shifts it out on SDA. It sits between the top-level SCL/SDA pins and the register map.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit device address this slave responds to
AUTO_INC, 1, 1: pointer increments after each data byte (write or acked read); 0: pointer holds

Ports:
clk  input  1  system clock; must be at least 16x SCL frequency
rst_n  input  1  asynchronous active-low reset
scl_i  input  1  raw SCL pin level (asynchronous)
sda_i  input  1  raw SDA pin level (asynchronous)
sda_oe  output  1  1 = pull SDA low (open-drain); top level ties pad to 0 when set, Z otherwise
reg_addr  output  8  register pointer presented to the register map
reg_wdata  output  8  write data, valid while reg_wen is high
reg_wen  output  1  one-cycle write strobe
reg_ren  output  1  one-cycle read strobe; reg_rdata is captured in the same cycle
reg_rdata  input  8  combinational read data from the register map
busy  output  1  high from an address-matched START until STOP

Behaviour:
- Reset (async, rst_n=0): state IDLE, sda_oe=0, reg_addr=0, reg_wdata=0, reg_wen=0, reg_ren=0, busy=0, synchronizers set to 1.
- Input path: 2-flop synchronizer on scl_i and sda_i, then a previous-value register. scl_rise/scl_fall/sda_rise/sda_fall are single-cycle pulses. Pin-to-event latency is 3 clk.
- START: sda_fall while SCL high. STOP: sda_rise while SCL high. Both are recognized in every state and override the state machine. START, including repeated START, goes to DEV_ADDR with bit counter 0. STOP goes to IDLE, releases SDA, and drops busy.
- SDA is sampled on scl_rise. sda_oe changes only on scl_fall.
- FSM states: IDLE, DEV_ADDR, ADDR_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- DEV_ADDR: shift 8 bits MSB first. On the 8th rising edge, compare bits [7:1] to SLAVE_ADDR.
  - Mismatch: IGNORE until START/STOP; sda_oe stays 0.
  - Match: busy=1, then ADDR_ACK.
- ADDR_ACK: assert sda_oe=1 on the following scl_fall and release it on the next scl_fall.
  - R/W=0: go to REG_PTR.
  - R/W=1: pulse reg_ren in the cycle of the ACK-ending scl_fall, latch reg_rdata into the tx shift register, drive MSB (sda_oe = ~bit) on that same edge, go to RD_DATA.
- REG_PTR: after 8 bits, reg_addr <= byte; ACK; go to WR_DATA. A repeated START followed by SLA+R then reads from that pointer.
- WR_DATA: after 8 bits, reg_wdata <= byte and reg_wen=1 for exactly one cycle, on the clk following the 8th scl_rise. ACK, and if AUTO_INC then reg_addr <= reg_addr+1 (8-bit wrap, 0xFF→0x00). Return to WR_DATA for further bytes.
- RD_DATA: shift the tx register on each scl_fall. After 8 bits, release SDA and enter RD_ACK.
- RD_ACK: sample master ACK on scl_rise.
  - ACK (SDA=0): if AUTO_INC, increment reg_addr. Pulse reg_ren at the next scl_fall, reload, continue RD_DATA.
  - NACK: release SDA, go to IGNORE until STOP/START.
- The slave always ACKs writes, including to read-only addresses (the map ignores them). No clock stretching.
- reg_wen and reg_ren are never high in the same cycle. Neither is issued in IDLE or IGNORE.
- STOP or START mid-byte discards the partial byte with no strobe. reset mid-transaction returns to IDLE immediately.

Decomposition:
- i2c_pkg: state enum i2c_state_t, ADDR_WIDTH=7, DATA_WIDTH=8.
- Sub-module i2c_line_sync: synchronizers plus edge/START/STOP detection, producing scl_rise, scl_fall, start_det, stop_det and sampled sda. The bridge instantiates one copy.

Test Plan:
- Write: START, 0x84, 0x01, 0xA5, STOP → three ACKs; reg_wen pulses once with reg_addr=0x01, reg_wdata=0xA5; reg_addr=0x02 afterwards.
- Burst write: START, 0x84, 0x01, 0x3C, 0x5A, STOP → two reg_wen pulses: (0x01,0x3C) then (0x02,0x5A); LED=0x5A3C.
- Random read with repeated START: SW[7:0]=0x96; START, 0x84, 0x00, Sr, 0x85, master NACK, STOP → bus returns 0x96; exactly one reg_ren with reg_addr=0x00.
- Sequential read: map holds 0x11 at 0x01 and 0x22 at 0x02; START, 0x84, 0x01, Sr, 0x85, ACK, NACK, STOP → bytes 0x11 then 0x22; two reg_ren pulses.
- Address mismatch: START, 0x86, 0x01, 0xFF, STOP → sda_oe never asserted, no strobes, busy stays 0.
- Abort and reset: STOP after 4 bits of a data byte → no reg_wen, back to IDLE. Separately, rst_n low mid-read → sda_oe=0 within the same cycle, all outputs at reset values.
